clk_div_prog: RTL and testbench

//  Multi-channel, runtime-programmable clock divider for the asteroid game
//  (RNG seeding, frame/animation rates). Each channel toggles clk_out every HALF

---
 rtl/clk_div_prog_pkg.sv | 15 +
 rtl/clk_div_chan.sv | 112 +++++++++++
 rtl/clk_div_prog.sv | 47 ++++
 tb/tb_clk_div_prog.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_prog_pkg.sv
// Shared defaults and the game's standard half-period constants for the
// programmable clock divider.
package clk_div_prog_pkg;

    localparam int unsigned CNT_W_STD    = 32'd16;
    localparam int unsigned N_CH_STD     = 32'd2;
    localparam int unsigned CH_W_STD     = 32'd1;
    localparam int unsigned DEF_HALF_STD = 32'd5;

    // Standard HALF values used by the game (period = 2*HALF clocks)
    localparam int unsigned HALF_RNG     = 32'd1;
    localparam int unsigned HALF_FRAME   = 32'd25000;
    localparam int unsigned HALF_BLINK   = 32'd12500;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow half-period, pending flag,
// divided clock, toggle tick and load acknowledge.
module clk_div_chan
    import clk_div_prog_pkg::*;
#(
    parameter int unsigned      CNT_W    = CNT_W_STD,
    parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEF_HALF_STD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    output logic             clk_out,
    output logic             tick,
    output logic             ack,
    output logic             pend
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] half_r;
    logic [CNT_W-1:0] shadow_r;
    logic             pend_r;
    logic             clk_out_r;
    logic             tick_r;
    logic             ack_r;
    logic             stopped_s;
    logic             last_s;

    // Terminal-count detect; >= keeps the channel safe even if cnt ever exceeds half-1
    always_comb begin
        stopped_s = (half_r == {CNT_W{1'b0}});
        if (stopped_s) begin
            last_s = 1'b0;
        end else begin
            last_s = (cnt_r >= (half_r - {{(CNT_W-1){1'b0}}, 1'b1}));
        end
    end

    // Channel state: sync beats toggle/en; new HALF only ever lands with cnt=0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            half_r    <= DEF_HALF;
            shadow_r  <= DEF_HALF;
            pend_r    <= 1'b0;
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
            ack_r     <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            ack_r  <= 1'b0;
            if (sync) begin
                cnt_r     <= {CNT_W{1'b0}};
                clk_out_r <= 1'b0;
                if (wr) begin
                    shadow_r <= wr_half;
                    half_r   <= wr_half;
                    pend_r   <= 1'b0;
                    ack_r    <= 1'b1;
                end else if (pend_r) begin
                    half_r <= shadow_r;
                    pend_r <= 1'b0;
                    ack_r  <= 1'b1;
                end else begin
                    pend_r <= 1'b0;
                end
            end else begin
                if (wr) begin
                    shadow_r <= wr_half;
                end else begin
                    shadow_r <= shadow_r;
                end
                if (stopped_s) begin
                    if (pend_r) begin
                        half_r <= shadow_r;
                        cnt_r  <= {CNT_W{1'b0}};
                        ack_r  <= 1'b1;
                    end else begin
                        half_r <= half_r;
                    end
                    pend_r <= wr;
                end else if (en && last_s) begin
                    cnt_r     <= {CNT_W{1'b0}};
                    clk_out_r <= ~clk_out_r;
                    tick_r    <= 1'b1;
                    if (pend_r) begin
                        half_r <= shadow_r;
                        ack_r  <= 1'b1;
                    end else begin
                        half_r <= half_r;
                    end
                    pend_r <= wr;
                end else begin
                    if (en) begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_r <= cnt_r;
                    end
                    pend_r <= pend_r | wr;
                end
            end
        end
    end

    assign clk_out = clk_out_r;
    assign tick    = tick_r;
    assign ack     = ack_r;
    assign pend    = pend_r;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock divider; decodes the shared load
// bus into per-channel writes and replicates the channel N_CH times.
module clk_div_prog
    import clk_div_prog_pkg::*;
#(
    parameter int unsigned      CNT_W    = CNT_W_STD,
    parameter int unsigned      N_CH     = N_CH_STD,
    parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEF_HALF_STD),
    parameter int unsigned      CH_W     = CH_W_STD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             ld,
    input  logic [CH_W-1:0]  ld_ch,
    input  logic [CNT_W-1:0] ld_half,
    output logic [N_CH-1:0]  ld_ack,
    output logic [N_CH-1:0]  pend,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick
);

    logic [N_CH-1:0] wr_s;

    // Channel numbers outside 0..N_CH-1 never match, so such loads are dropped
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign wr_s[i] = ld && (ld_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .sync     (sync),
            .wr       (wr_s[i]),
            .wr_half  (ld_half),
            .clk_out  (clk_out[i]),
            .tick     (tick[i]),
            .ack      (ld_ack[i]),
            .pend     (pend[i])
        );
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios plus randomized
// traffic, all compared against a per-channel behavioural model.
module tb_clk_div_prog;

    localparam int N = 2;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        en      = 1'b0;
    logic        sync    = 1'b0;
    logic        ld      = 1'b0;
    logic [1:0]  ld_ch   = 2'd0;
    logic [15:0] ld_half = 16'd0;
    logic [1:0]  ld_ack;
    logic [1:0]  pend;
    logic [1:0]  clk_out;
    logic [1:0]  tick;

    clk_div_prog #(
        .CNT_W    (16),
        .N_CH     (2),
        .DEF_HALF (16'd5),
        .CH_W     (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .ld       (ld),
        .ld_ch    (ld_ch),
        .ld_half  (ld_half),
        .ld_ack   (ld_ack),
        .pend     (pend),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: enabled cycles elapsed since the last phase origin, per channel
    int m_half   [N];
    int m_shadow [N];
    int m_since  [N];
    bit m_pend   [N];
    bit m_clk    [N];
    bit m_tick   [N];
    bit m_ack    [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_half[c]   = 5;
            m_shadow[c] = 5;
            m_since[c]  = 0;
            m_pend[c]   = 1'b0;
            m_clk[c]    = 1'b0;
            m_tick[c]   = 1'b0;
            m_ack[c]    = 1'b0;
        end
    endtask

    task automatic model_step(input bit e, input bit s, input bit l, input int lc, input int lh);
        for (int c = 0; c < N; c++) begin
            bit wr;
            bit op;
            int osh;
            wr  = l && (lc == c);
            op  = m_pend[c];
            osh = m_shadow[c];
            m_tick[c] = 1'b0;
            m_ack[c]  = 1'b0;
            if (s) begin
                m_since[c] = 0;
                m_clk[c]   = 1'b0;
                if (wr) begin
                    m_half[c] = lh; m_shadow[c] = lh; m_pend[c] = 1'b0; m_ack[c] = 1'b1;
                end else if (op) begin
                    m_half[c] = osh; m_pend[c] = 1'b0; m_ack[c] = 1'b1;
                end
            end else begin
                if (wr) m_shadow[c] = lh;
                if (m_half[c] == 0) begin
                    if (op) begin
                        m_half[c] = osh; m_since[c] = 0; m_pend[c] = 1'b0; m_ack[c] = 1'b1;
                    end
                end else if (e) begin
                    m_since[c]++;
                    if (m_since[c] == m_half[c]) begin
                        m_since[c] = 0;
                        m_clk[c]   = !m_clk[c];
                        m_tick[c]  = 1'b1;
                        if (op) begin
                            m_half[c] = osh; m_pend[c] = 1'b0; m_ack[c] = 1'b1;
                        end
                    end
                end
                if (wr) m_pend[c] = 1'b1;
            end
        end
    endtask

    task automatic compare(input string tag);
        logic [1:0] e_clk, e_tick, e_ack, e_pend;
        for (int c = 0; c < N; c++) begin
            e_clk[c]  = m_clk[c];
            e_tick[c] = m_tick[c];
            e_ack[c]  = m_ack[c];
            e_pend[c] = m_pend[c];
        end
        chk({tag, ".clk_out"}, 32'(clk_out), 32'(e_clk));
        chk({tag, ".tick"},    32'(tick),    32'(e_tick));
        chk({tag, ".ld_ack"},  32'(ld_ack),  32'(e_ack));
        chk({tag, ".pend"},    32'(pend),    32'(e_pend));
    endtask

    // Called at a negedge: drive inputs, clock once, check at the next negedge
    task automatic cycle(input string tag, input bit e, input bit s, input bit l,
                         input int lc, input int lh);
        en      = e;
        sync    = s;
        ld      = l;
        ld_ch   = 2'(lc);
        ld_half = 16'(lh);
        @(posedge clk);
        model_step(e, s, l, lc, lh);
        @(negedge clk);
        compare(tag);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge
    task automatic do_reset(input string tag);
        #2;
        rst  = 1'b0;
        sync = 1'b0;
        ld   = 1'b0;
        #1;
        model_reset();
        compare(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        compare("rst0");
        @(negedge clk);
        rst = 1'b1;

        // 1: defaults, period 10, ticks at 5/10/15
        for (int k = 1; k <= 15; k++) begin
            cycle("t1", 1'b1, 1'b0, 1'b0, 0, 0);
            chk("t1.tick_fix", 32'(tick), (k % 5 == 0) ? 32'd3 : 32'd0);
            chk("t1.clk_fix", 32'(clk_out), (((k / 5) % 2) == 1) ? 32'd3 : 32'd0);
        end

        // 2: ld ch0 HALF=3 at clk 2 -> applies at clk 5, then toggles at 8, 11
        do_reset("t2rst");
        for (int k = 1; k <= 14; k++) begin
            cycle("t2", 1'b1, 1'b0, (k == 2), 0, 3);
            chk("t2.tick0_fix", 32'(tick[0]), (k == 5 || k == 8 || k == 11 || k == 14) ? 32'd1 : 32'd0);
            chk("t2.ack0_fix", 32'(ld_ack[0]), (k == 5) ? 32'd1 : 32'd0);
        end

        // 3: ch1 stopped by HALF=0, then restarted with HALF=1
        cycle("t3", 1'b1, 1'b0, 1'b1, 1, 0);
        for (int k = 0; k < 8; k++) cycle("t3", 1'b1, 1'b0, 1'b0, 0, 0);
        cycle("t3", 1'b1, 1'b0, 1'b1, 1, 1);
        for (int k = 0; k < 6; k++) cycle("t3", 1'b1, 1'b0, 1'b0, 0, 0);

        // 4: en low for 7 clocks mid-count, with a load accepted meanwhile
        cycle("t4", 1'b1, 1'b0, 1'b1, 1, 5);
        for (int k = 0; k < 3; k++) cycle("t4", 1'b1, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 7; k++) cycle("t4", 1'b0, 1'b0, (k == 2), 0, 4);
        for (int k = 0; k < 12; k++) cycle("t4", 1'b1, 1'b0, 1'b0, 0, 0);

        // 5: sync with a same-cycle load on ch1
        cycle("t5", 1'b1, 1'b0, 1'b1, 0, 3);
        for (int k = 0; k < 7; k++) cycle("t5", 1'b1, 1'b0, 1'b0, 0, 0);
        cycle("t5", 1'b1, 1'b1, 1'b1, 1, 4);
        for (int k = 0; k < 10; k++) cycle("t5", 1'b1, 1'b0, 1'b0, 0, 0);

        // 6: reset with a pending load, then an out-of-range channel load
        cycle("t6", 1'b1, 1'b0, 1'b1, 0, 2);
        cycle("t6", 1'b1, 1'b0, 1'b0, 0, 0);
        do_reset("t6rst");
        cycle("t6", 1'b1, 1'b0, 1'b1, 3, 2);
        chk("t6.pend_fix", 32'(pend), 32'd0);
        for (int k = 0; k < 10; k++) cycle("t6", 1'b1, 1'b0, 1'b0, 0, 0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset("rnd_rst");
            end else begin
                cycle("rnd",
                      ($urandom_range(0, 9) != 0),
                      ($urandom_range(0, 49) == 0),
                      ($urandom_range(0, 7) == 0),
                      int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 6)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
